// File: rtl/vga_rx.sv
// VGA timing receiver: recovers h/line position from sync edges, verifies
// frame timing, and emits a coordinate-tagged pixel stream once locked.
module vga_rx #(
   parameter int SIZE_H        = 640,
   parameter int SIZE_V        = 480,
   parameter int BACK_PORCH_H  = 48,
   parameter int FRONT_PORCH_H = 16,
   parameter int SYNC_H_PX     = 96,
   parameter int BACK_PORCH_V  = 33,
   parameter int FRONT_PORCH_V = 10,
   parameter int SYNC_V_LINE   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sync_h,
   input  logic       sync_v,
   input  logic [3:0] r,
   input  logic [3:0] g,
   input  logic [3:0] b,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       pix_de,
   output logic [3:0] pix_r,
   output logic [3:0] pix_g,
   output logic [3:0] pix_b,
   output logic       frame_start,
   output logic       locked,
   output logic [7:0] err_cnt
);
   localparam int H_MAX = SIZE_H + BACK_PORCH_H + FRONT_PORCH_H + SYNC_H_PX;
   localparam int V_MAX = SIZE_V + BACK_PORCH_V + FRONT_PORCH_V + SYNC_V_LINE;
   localparam logic [9:0] H_LAST = 10'(H_MAX - 1);
   localparam logic [9:0] H_OVER = 10'(H_MAX);
   localparam logic [9:0] V_LAST = 10'(V_MAX - 1);
   localparam logic [9:0] V_OVER = 10'(V_MAX);
   localparam logic [9:0] X_LO   = 10'(BACK_PORCH_H);
   localparam logic [9:0] X_HI   = 10'(BACK_PORCH_H + SIZE_H);
   localparam logic [9:0] Y_LO   = 10'(BACK_PORCH_V);
   localparam logic [9:0] Y_HI   = 10'(BACK_PORCH_V + SIZE_V);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_LOCKED} state_t;

   state_t      state_q, state_d;
   logic        sync_h_q, sync_h_d, sync_v_q, sync_v_d;
   logic        sync_h_prev_q, sync_h_prev_d, sync_v_prev_q, sync_v_prev_d;
   logic [11:0] rgb_q, rgb_d;
   logic [9:0]  h_q, h_d, line_q, line_d;
   logic        v_pend_q, v_pend_d;
   logic [7:0]  err_q, err_d;
   logic        h_rise, v_rise, line0, viol;
   logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic        pix_de_q, pix_de_d, fs_q, fs_d, lock_q, lock_d;
   logic [11:0] pix_rgb_q, pix_rgb_d;

   // Position tracking and timing checks on the stage-1 sample.
   always_comb begin
      sync_h_d      = sync_h;
      sync_v_d      = sync_v;
      sync_h_prev_d = sync_h_q;
      sync_v_prev_d = sync_v_q;
      rgb_d         = {r, g, b};
      h_rise        = sync_h_q & ~sync_h_prev_q;
      v_rise        = sync_v_q & ~sync_v_prev_q;
      line0         = h_rise & (v_rise | v_pend_q);
      h_d           = h_rise ? 10'd0 : ((h_q == 10'h3FF) ? h_q : h_q + 10'd1);
      v_pend_d      = h_rise ? 1'b0 : (v_pend_q | v_rise);
      line_d        = line_q;
      if (h_rise)
         line_d = line0 ? 10'd0 : ((line_q == 10'h3FF) ? line_q : line_q + 10'd1);
      viol = 1'b0;
      if (h_rise && (h_q != H_LAST))                          viol = 1'b1;
      if (!h_rise && (h_d == H_OVER))                         viol = 1'b1;
      if (line0 && (line_q != V_LAST) && (state_q != S_IDLE)) viol = 1'b1;
      if (h_rise && (line_d == V_OVER))                       viol = 1'b1;
      err_d = err_q;
      if (viol && (state_q != S_IDLE) && (err_q != 8'hFF))
         err_d = err_q + 8'd1;
   end

   // A violation on a line-0 sample wins over entering or advancing lock.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (line0 && !viol) state_d = S_CHECK;
         S_CHECK:  if (viol) state_d = S_IDLE;
                   else if (line0) state_d = S_LOCKED;
         S_LOCKED: if (viol) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // pix_de qualifies each output beat; there is no ready, so the consumer
   // must take every beat it sees.
   always_comb begin
      lock_d    = (state_d == S_LOCKED);
      pix_de_d  = lock_d && (h_d >= X_LO) && (h_d < X_HI) && (line_d >= Y_LO) && (line_d < Y_HI);
      pix_x_d   = pix_de_d ? h_d - X_LO : 10'd0;
      pix_y_d   = pix_de_d ? line_d - Y_LO : 10'd0;
      pix_rgb_d = pix_de_d ? rgb_q : 12'd0;
      fs_d      = pix_de_d && (pix_x_d == 10'd0) && (pix_y_d == 10'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Sync registers reset high so a sync held high across reset is not a rise.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_h_q      <= 1'b1;
         sync_v_q      <= 1'b1;
         sync_h_prev_q <= 1'b1;
         sync_v_prev_q <= 1'b1;
         rgb_q         <= '0;
         h_q           <= '0;
         line_q        <= '0;
         v_pend_q      <= 1'b0;
         err_q         <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_de_q      <= 1'b0;
         pix_rgb_q     <= '0;
         fs_q          <= 1'b0;
         lock_q        <= 1'b0;
      end else begin
         sync_h_q      <= sync_h_d;
         sync_v_q      <= sync_v_d;
         sync_h_prev_q <= sync_h_prev_d;
         sync_v_prev_q <= sync_v_prev_d;
         rgb_q         <= rgb_d;
         h_q           <= h_d;
         line_q        <= line_d;
         v_pend_q      <= v_pend_d;
         err_q         <= err_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_de_q      <= pix_de_d;
         pix_rgb_q     <= pix_rgb_d;
         fs_q          <= fs_d;
         lock_q        <= lock_d;
      end
   end

   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_de      = pix_de_q;
   assign pix_r       = pix_rgb_q[11:8];
   assign pix_g       = pix_rgb_q[7:4];
   assign pix_b       = pix_rgb_q[3:0];
   assign frame_start = fs_q;
   assign locked      = lock_q;
   assign err_cnt     = err_q;
endmodule

// File: tb/tb_vga_rx.sv
// Bench for vga_rx on a reduced 11x7 timing: frame-by-frame scenario table
// plus hand sequences for mid-frame reset and error-counter saturation.
module tb_vga_rx;
   localparam int BPH = 2, SZH = 6, FPH = 1, SYH = 2;
   localparam int BPV = 2, SZV = 3, FPV = 1, SYV = 1;
   localparam int HMAX = BPH + SZH + FPH + SYH;  // 11
   localparam int VMAX = BPV + SZV + FPV + SYV;  // 7

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sync_h = 1'b1, sync_v = 1'b1;
   logic [3:0] r = '0, g = '0, b = '0;
   logic [9:0] pix_x, pix_y;
   logic       pix_de, frame_start, locked;
   logic [3:0] pix_r, pix_g, pix_b;
   logic [7:0] err_cnt;

   vga_rx #(
      .SIZE_H(SZH), .SIZE_V(SZV), .BACK_PORCH_H(BPH), .FRONT_PORCH_H(FPH),
      .SYNC_H_PX(SYH), .BACK_PORCH_V(BPV), .FRONT_PORCH_V(FPV), .SYNC_V_LINE(SYV)
   ) dut (
      .clk(clk), .reset(reset), .sync_h(sync_h), .sync_v(sync_v),
      .r(r), .g(g), .b(b),
      .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .frame_start(frame_start), .locked(locked), .err_cnt(err_cnt)
   );

   // clock / reset
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int drv_idx = -1000;

   // Output monitor: obs is the index of the input sample now seen at the outputs.
   int mon_de = 0, mon_fs = 0, mon_hit = 0, hit_x = -1, hit_y = -1, inv_bad = 0;
   int rise_idx = -1, fall_idx = -1;
   logic prev_lock = 1'b0, prev_de = 1'b0;
   logic [9:0] prev_x = '0;

   always @(negedge clk) begin : monitor
      int obs;
      obs = drv_idx - 2;
      if (locked && !prev_lock) rise_idx = obs;
      if (!locked && prev_lock) fall_idx = obs;
      prev_lock = locked;
      if (pix_de) begin
         mon_de++;
         if (prev_de ? (pix_x != prev_x + 10'd1) : (pix_x != 10'd0)) inv_bad++;
         if (pix_x >= 10'(SZH) || pix_y >= 10'(SZV)) inv_bad++;
      end else if (pix_x != 0 || pix_y != 0 || pix_r != 0 || pix_g != 0 || pix_b != 0) begin
         inv_bad++;
      end
      if (frame_start) begin
         mon_fs++;
         if (!(pix_de && pix_x == 0 && pix_y == 0)) inv_bad++;
      end
      if (pix_r == 4'd15) begin
         mon_hit++;
         hit_x = int'(pix_x);
         hit_y = int'(pix_y);
         if (pix_g != 4'd15 || pix_b != 4'd15) inv_bad++;
      end
      prev_de = pix_de;
      prev_x  = pix_x;
   end

   // scoreboard helpers
   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_pix_x"}, int'(pix_x), 0);
      check({tag, "_pix_y"}, int'(pix_y), 0);
      check({tag, "_pix_de"}, int'(pix_de), 0);
      check({tag, "_rgb"}, int'({pix_r, pix_g, pix_b}), 0);
      check({tag, "_frame_start"}, int'(frame_start), 0);
      check({tag, "_locked"}, int'(locked), 0);
      check({tag, "_err_cnt"}, int'(err_cnt), 0);
   endtask

   // driver tasks
   function automatic logic [3:0] col_fn(input int h, input int v);
      if (h == BPH + 3 && v == BPV + 1) return 4'd15;  // pixel (3,1)
      if (h == 0) return 4'd10;                        // blanking, must not appear
      return 4'd0;
   endfunction

   task automatic step(input logic hs, input logic vs, input logic [3:0] c, input logic rst);
      drv_idx++;
      sync_h = hs;
      sync_v = vs;
      r = c; g = c; b = c;
      reset = rst;
      @(posedge clk);
      #1;
   endtask

   task automatic gen_line(input int len, input logic vs_low, input logic rst0, input int v);
      for (int h = 0; h < len; h++) begin
         step(h < len - SYH, !vs_low, col_fn(h, v), rst0 && (h == 0));
         if (rst0 && h == 0) check_zero("mid_reset");
      end
   endtask

   task automatic gen_frame(input int short_line, input int no_vs, input int rst_line);
      for (int v = 0; v < VMAX; v++)
         gen_line((v == short_line) ? HMAX - 3 : HMAX,
                  (v == VMAX - 1) && (no_vs == 0), v == rst_line, v);
   endtask

   typedef struct {
      int short_line;
      int no_vs;
      int rst_line;
      int exp_lock;
      int exp_err;
      int exp_de;
      int exp_fs;
      int exp_hit;
      int rise_off;
      int fall_off;
   } row_t;

   row_t tbl[17];

   initial begin
      int g0, de0, fs0, hit0;
      tbl[0]  = '{-1, 0, -1, 0, 0,  0, 0, 0, -1, -1};  // first line0 arrives at row1 start
      tbl[1]  = '{-1, 0, -1, 0, 0,  0, 0, 0, -1, -1};  // IDLE -> CHECK
      tbl[2]  = '{-1, 0, -1, 1, 0, 18, 1, 1,  0, -1};  // CHECK -> LOCKED
      tbl[3]  = '{ 4, 0, -1, 0, 1, 18, 1, 1, -1, 52};  // short line 4
      tbl[4]  = '{-1, 0, -1, 0, 1,  0, 0, 0, -1, -1};
      tbl[5]  = '{-1, 0, -1, 1, 1, 18, 1, 1,  0, -1};
      tbl[6]  = '{-1, 1, -1, 1, 1, 18, 1, 1, -1, -1};  // vsync withheld at end
      tbl[7]  = '{-1, 0, -1, 0, 2,  0, 0, 0, -1,  0};  // line reaches VMAX
      tbl[8]  = '{-1, 0, -1, 0, 2,  0, 0, 0, -1, -1};
      tbl[9]  = '{-1, 0, -1, 1, 2, 18, 1, 1,  0, -1};
      tbl[10] = '{ 6, 0, -1, 1, 2, 18, 1, 1, -1, -1};  // last line short
      tbl[11] = '{-1, 0, -1, 0, 3,  0, 0, 0, -1,  0};  // viol beats line0
      tbl[12] = '{-1, 0, -1, 0, 3,  0, 0, 0, -1, -1};
      tbl[13] = '{-1, 0, -1, 1, 3, 18, 1, 1,  0, -1};
      tbl[14] = '{-1, 0,  3, 0, 0,  6, 1, 0, -1, 32};  // reset at line 3
      tbl[15] = '{-1, 0, -1, 0, 0,  0, 0, 0, -1, -1};
      tbl[16] = '{-1, 0, -1, 1, 0, 18, 1, 1,  0, -1};

      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd0, 1'b1);
      check_zero("reset");
      drv_idx = -1;

      for (int i = 0; i < 17; i++) begin
         g0   = drv_idx + 1;
         de0  = mon_de;
         fs0  = mon_fs;
         hit0 = mon_hit;
         gen_frame(tbl[i].short_line, tbl[i].no_vs, tbl[i].rst_line);
         check($sformatf("row%0d_locked", i), int'(locked), tbl[i].exp_lock);
         check($sformatf("row%0d_err_cnt", i), int'(err_cnt), tbl[i].exp_err);
         check($sformatf("row%0d_de_count", i), mon_de - de0, tbl[i].exp_de);
         check($sformatf("row%0d_fs_count", i), mon_fs - fs0, tbl[i].exp_fs);
         check($sformatf("row%0d_hit_count", i), mon_hit - hit0, tbl[i].exp_hit);
         if (tbl[i].exp_hit == 1) begin
            check($sformatf("row%0d_hit_x", i), hit_x, 3);
            check($sformatf("row%0d_hit_y", i), hit_y, 1);
         end
         if (tbl[i].rise_off >= 0)
            check($sformatf("row%0d_lock_rise", i), rise_idx, g0 + tbl[i].rise_off);
         if (tbl[i].fall_off >= 0)
            check($sformatf("row%0d_lock_fall", i), fall_idx, g0 + tbl[i].fall_off);
      end

      // One counted violation per mini-frame: line0 re-enters CHECK, short line breaks it.
      for (int k = 0; k < 300; k++) begin
         gen_line(HMAX, 1'b0, 1'b0, 0);
         gen_line(HMAX - 3, 1'b0, 1'b0, 1);
         gen_line(HMAX, 1'b1, 1'b0, 2);
         if (k == 9) check("sat_err_after_10", int'(err_cnt), 10);
      end
      check("sat_err_final", int'(err_cnt), 255);
      check("sat_locked", int'(locked), 0);
      check("output_invariants", inv_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
